// File: rtl/pipelined_carry_select_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_carry_select_adder_if                                      |
// | Operand/result handshake bundle for the pipelined carry-select adder |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipelined_carry_select_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_carry_select_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_carry_select_adder                                         |
// | One BLOCK-bit carry-select slice per stage, global-stall handshake.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipelined_carry_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  pipelined_carry_select_adder_if.slave bus_if
);

  localparam int NBLK = WIDTH / BLOCK;

  generate
    if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_param_check
      $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
    end
  endgenerate

  // Per-stage inputs: stage 0 reads the ports, stage k reads stage k-1.
  logic [WIDTH-1:0] a_in   [NBLK];
  logic [WIDTH-1:0] be_in  [NBLK];
  logic [WIDTH-1:0] sum_in [NBLK];
  logic             c_in   [NBLK];
  logic             v_in   [NBLK];

  logic [BLOCK:0]   sum0   [NBLK];
  logic [BLOCK:0]   sum1   [NBLK];
  logic [BLOCK:0]   sel    [NBLK];
  logic [WIDTH-1:0] sum_d  [NBLK];
  logic             carry_d[NBLK];
  logic             ovf_d;

  logic [WIDTH-1:0] a_q    [NBLK];
  logic [WIDTH-1:0] be_q   [NBLK];
  logic [WIDTH-1:0] sum_q  [NBLK];
  logic             c_q    [NBLK];
  logic             v_q    [NBLK];
  logic             ovf_q;

  logic             stall;

  assign stall           = v_q[NBLK-1] & ~bus_if.out_ready;
  assign bus_if.in_ready = ~stall;

  // Subtraction as a + ~b + ~cin: inverting the borrow-in turns it into a carry.
  always_comb begin
    a_in[0]   = bus_if.a;
    be_in[0]  = bus_if.sub ? ~bus_if.b : bus_if.b;
    c_in[0]   = bus_if.cin ^ bus_if.sub;
    sum_in[0] = '0;
    v_in[0]   = bus_if.in_valid;
    for (int k = 1; k < NBLK; k++) begin
      a_in[k]   = a_q[k-1];
      be_in[k]  = be_q[k-1];
      c_in[k]   = c_q[k-1];
      sum_in[k] = sum_q[k-1];
      v_in[k]   = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      sum0[k] = {1'b0, a_in[k][k*BLOCK +: BLOCK]} + {1'b0, be_in[k][k*BLOCK +: BLOCK]};
      sum1[k] = {1'b0, a_in[k][k*BLOCK +: BLOCK]} + {1'b0, be_in[k][k*BLOCK +: BLOCK]}
                + (BLOCK+1)'(1);
      sel[k]  = c_in[k] ? sum1[k] : sum0[k];
      sum_d[k] = sum_in[k];
      sum_d[k][k*BLOCK +: BLOCK] = sel[k][BLOCK-1:0];
      carry_d[k] = sel[k][BLOCK];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_d = (sum_d[NBLK-1][WIDTH-1] ^ a_in[NBLK-1][WIDTH-1] ^ be_in[NBLK-1][WIDTH-1])
            ^ carry_d[NBLK-1];
  end

  // Data registers load only with a valid op so outputs hold across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        be_q[k]  <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NBLK; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k]   <= a_in[k];
          be_q[k]  <= be_in[k];
          sum_q[k] <= sum_d[k];
          c_q[k]   <= carry_d[k];
        end
      end
      if (v_in[NBLK-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus_if.out_valid = v_q[NBLK-1];
  assign bus_if.sum       = sum_q[NBLK-1];
  assign bus_if.cout      = c_q[NBLK-1];
  assign bus_if.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_select_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_carry_select_adder                                      |
// | Randomised and directed bench against an arithmetic reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipelined_carry_select_adder;

  localparam int W  = 16;
  localparam int BL = 4;
  localparam int SW = 4;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    bit          lit;
    logic [15:0] ls;
    logic        lco;
    logic        lov;
    bit          cco;
    bit          cov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_carry_select_adder_if #(.WIDTH(W))  m_if ();
  pipelined_carry_select_adder_if #(.WIDTH(SW)) s_if ();

  pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(BL)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (m_if.slave)
  );

  pipelined_carry_select_adder #(.WIDTH(SW), .BLOCK(SW)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .bus_if (s_if.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   g_step;
  bit   g_acc, g_xfer, g_ov, g_stall;
  exp_t q[$];

  bit          nx_lit = 1'b0;
  logic [15:0] nx_ls;
  logic        nx_lco, nx_lov;
  bit          nx_cco, nx_cov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic void model(input int w, input longint a, input longint b,
                                input longint ci, input longint sb,
                                output longint s, output logic co, output logic ov);
    longint m, t, sa, sbv, ts;
    m   = longint'(1) << w;
    sa  = (a >= m/2) ? a - m : a;
    sbv = (b >= m/2) ? b - m : b;
    if (sb == 0) begin
      t  = a + b + ci;
      co = (t >= m);
      s  = t % m;
      ts = sa + sbv + ci;
    end else begin
      t  = a - b - ci;
      co = (t >= 0);
      s  = (t + m) % m;
      ts = sa - sbv - ci;
    end
    ov = (ts < -(m/2)) || (ts >= m/2);
  endfunction

  task automatic step();
    exp_t   e;
    longint s;
    logic   co, ov;
    #1;
    chk("in_ready", m_if.in_ready, !(m_if.out_valid && !m_if.out_ready));
    g_xfer  = m_if.out_valid && m_if.out_ready;
    g_acc   = m_if.in_valid && m_if.in_ready;
    g_ov    = m_if.out_valid;
    g_stall = m_if.out_valid && !m_if.out_ready;
    if (g_xfer) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got out_valid=1 sum=%0h, expected no pending op", m_if.sum);
      end else begin
        e = q.pop_front();
        chk("sum", m_if.sum, e.s);
        chk("cout", m_if.cout, e.co);
        chk("ovf", m_if.ovf, e.ov);
        if (e.lit) chk("lit_sum", m_if.sum, e.ls);
        if (e.cco) chk("lit_cout", m_if.cout, e.lco);
        if (e.cov) chk("lit_ovf", m_if.ovf, e.lov);
      end
    end
    if (g_acc) begin
      model(W, longint'(m_if.a), longint'(m_if.b), longint'(m_if.cin), longint'(m_if.sub), s, co, ov);
      e.s   = s[15:0];
      e.co  = co;
      e.ov  = ov;
      e.lit = nx_lit;
      e.ls  = nx_ls;
      e.lco = nx_lco;
      e.lov = nx_lov;
      e.cco = nx_lit && nx_cco;
      e.cov = nx_lit && nx_cov;
      q.push_back(e);
      nx_lit = 1'b0;
    end
    g_step = cyc;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_ops();
    m_if.a   = 16'($urandom);
    m_if.b   = 16'($urandom);
    m_if.cin = 1'($urandom);
    m_if.sub = 1'($urandom);
  endtask

  task automatic send_dir(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input logic [15:0] ls, input logic lco,
                          input logic lov, input bit cco, input bit cov);
    m_if.a = a; m_if.b = b; m_if.cin = ci; m_if.sub = sb;
    m_if.in_valid = 1'b1;
    nx_lit = 1'b1; nx_ls = ls; nx_lco = lco; nx_lov = lov; nx_cco = cco; nx_cov = cov;
    step();
    chk("dir_accept", g_acc, 1'b1);
  endtask

  task automatic drain();
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int first_acc, first_v, last_v, nv, nst, sent;
    logic [4:0]  lit4 [5];
    logic [3:0]  va [5], vb [5];
    logic        vc [5];
    longint      s4;
    logic        co4, ov4;

    rst = 1'b1;
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    m_if.a = '0; m_if.b = '0; m_if.cin = 1'b0; m_if.sub = 1'b0;
    s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
    s_if.a = '0; s_if.b = '0; s_if.cin = 1'b0; s_if.sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", m_if.out_valid, 1'b0);
    chk("rst_sum", m_if.sum, 16'h0);
    chk("rst_cout", m_if.cout, 1'b0);
    chk("rst_ovf", m_if.ovf, 1'b0);
    chk("rst_out_valid4", s_if.out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", m_if.in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors with hand-computed results.
    send_dir(16'h8000, 16'h0003, 1'b0, 1'b0, 16'h8003, 1'b0, 1'b0, 1, 1);
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, 1);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 1);
    send_dir(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1, 0);
    drain();

    // Latency and throughput: 8 back-to-back ops, consumer always ready.
    first_acc = -1; first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 20; i++) begin
      m_if.in_valid = (i < 8);
      rand_ops();
      step();
      if (g_acc && first_acc < 0) first_acc = g_step + 1;
      if (g_ov) begin
        if (first_v < 0) first_v = g_step;
        last_v = g_step;
        nv++;
      end
    end
    chk("latency", first_v - first_acc, 3);
    chk("valid_run", nv, 8);
    chk("valid_contig", last_v - first_v, 7);
    drain();

    // Backpressure: consumer drops ready for three cycles mid-stream.
    sent = 0; nst = 0;
    rand_ops();
    for (int i = 0; i < 30; i++) begin
      m_if.in_valid  = (sent < 6);
      m_if.out_ready = !(i >= 5 && i < 8);
      step();
      if (g_stall) nst++;
      if (g_acc) begin
        sent++;
        rand_ops();
      end
    end
    chk("stall_cycles", nst, 3);
    chk("bp_sent", sent, 6);
    drain();

    // Reset with three ops in flight.
    m_if.a = 16'h1234; m_if.b = 16'h0101; m_if.cin = 1'b0; m_if.sub = 1'b0;
    m_if.in_valid = 1'b1;
    step();
    step();
    step();
    m_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", m_if.out_valid, 1'b0);
    chk("mid_rst_sum", m_if.sum, 16'h0);
    chk("mid_rst_cout", m_if.cout, 1'b0);
    chk("mid_rst_ovf", m_if.ovf, 1'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (g_ov) nv++;
    end
    chk("no_stale", nv, 0);

    // Random traffic with random backpressure and operand churn while stalled.
    for (int i = 0; i < 300; i++) begin
      m_if.in_valid  = ($urandom_range(0, 9) < 7);
      m_if.out_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      step();
    end
    drain();

    // Single-stage instance: result visible right after the accepting edge.
    va[0] = 4'h8; vb[0] = 4'h3; vc[0] = 1'b0; lit4[0] = 5'b01011;
    va[1] = 4'h3; vb[1] = 4'hA; vc[1] = 1'b1; lit4[1] = 5'b01110;
    va[2] = 4'h6; vb[2] = 4'h6; vc[2] = 1'b0; lit4[2] = 5'b01100;
    va[3] = 4'h7; vb[3] = 4'hE; vc[3] = 1'b0; lit4[3] = 5'b10101;
    va[4] = 4'hE; vb[4] = 4'hE; vc[4] = 1'b1; lit4[4] = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      s_if.a = va[i]; s_if.b = vb[i]; s_if.cin = vc[i]; s_if.sub = 1'b0;
      s_if.in_valid = 1'b1;
      #1;
      chk("n1_in_ready", s_if.in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      s_if.in_valid = 1'b0;
      #1;
      model(SW, longint'(va[i]), longint'(vb[i]), longint'(vc[i]), 0, s4, co4, ov4);
      chk("n1_out_valid", s_if.out_valid, 1'b1);
      chk("n1_cout_sum", {s_if.cout, s_if.sum}, lit4[i]);
      chk("n1_ovf", s_if.ovf, ov4);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
